// File: rtl/delay_align_sequencer_if.sv
// delay_align_sequencer_if: this bundle carries the control and status signals
// between the slow-control side and the alignment sequencer, together with the
// per-lane ready/eye/mode signals of the delay controllers.
// The master modport is the register block and lane side. The slave modport is
// the sequencer.
interface delay_align_sequencer_if #(
    parameter int NUM_LANES = 8,
    parameter int TIMEOUT_W = 20
);
    logic                   start;
    logic                   abort;
    logic [NUM_LANES-1:0]   lane_mask;
    logic [5:0]             min_eye;
    logic [TIMEOUT_W-1:0]   timeout_cycles;
    logic [NUM_LANES-1:0]   lane_ready;
    logic [6*NUM_LANES-1:0] lane_eye_width;
    logic [NUM_LANES-1:0]   lane_delay_mode;
    logic                   busy;
    logic                   done;
    logic [3:0]             cur_lane;
    logic [NUM_LANES-1:0]   lane_ok;
    logic [NUM_LANES-1:0]   lane_fail;
    logic [5:0]             eye_min;

    modport master (
        output start, abort, lane_mask, min_eye, timeout_cycles, lane_ready, lane_eye_width,
        input  lane_delay_mode, busy, done, cur_lane, lane_ok, lane_fail, eye_min
    );

    modport slave (
        input  start, abort, lane_mask, min_eye, timeout_cycles, lane_ready, lane_eye_width,
        output lane_delay_mode, busy, done, cur_lane, lane_ok, lane_fail, eye_min
    );
endinterface

// File: rtl/delay_align_sequencer.sv
// delay_align_sequencer: this block calibrates a link by aligning its delay
// lanes one lane at a time. For each lane that takes part, it raises the lane's
// delay_mode and masks the stale ready during AUTOINIT. It then waits for ready,
// with an optional timeout, and compares eye_width against the captured minimum.
// The block records pass/fail per lane and the narrowest passing eye.
// Optional feature: define DELAY_SEQ_RETRY_EN to re-arm a failing lane up to
// MAX_RETRY extra times before its failure is recorded.
module delay_align_sequencer #(
    parameter int NUM_LANES = 8,
    parameter int TIMEOUT_W = 20,
    parameter int MAX_RETRY = 3
) (
    input logic                    clk160,
    input logic                    totalCounterResetb_manual,
    delay_align_sequencer_if.slave bus
);
    if (NUM_LANES < 1 || NUM_LANES > 16 || TIMEOUT_W < 1 || MAX_RETRY < 0) begin : g_bad_params
        $error("delay_align_sequencer: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_SELECT,
        S_ARM,
        S_SETTLE,
        S_WAIT_READY,
        S_CHECK,
        S_NEXT,
        S_FINISH
`ifdef DELAY_SEQ_RETRY_EN
        , S_RETRY_WAIT
`endif
    } state_t;

    state_t                 state;
    logic [NUM_LANES-1:0]   mode_r;
    logic [NUM_LANES-1:0]   ok_r;
    logic [NUM_LANES-1:0]   fail_r;
    logic [NUM_LANES-1:0]   mask_r;
    logic                   busy_r;
    logic                   done_r;
    logic [3:0]             cur_lane_r;
    logic [5:0]             eye_min_r;
    logic [5:0]             min_eye_r;
    logic [TIMEOUT_W-1:0]   tmo_r;
    logic [TIMEOUT_W-1:0]   tmo_cnt;
    logic [1:0]             settle_cnt;
`ifdef DELAY_SEQ_RETRY_EN
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;
    logic [RETRY_W-1:0]     retry_cnt;
    logic                   gap_cnt;
`endif

    logic [NUM_LANES-1:0]   lane_bit;
    logic [6:0]             eye_sh;
    logic [5:0]             cur_eye;
    logic                   cur_ready;
    logic                   cur_masked;

    function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + TIMEOUT_W'(1);
    endfunction

    function automatic logic [5:0] min6(input logic [5:0] a, input logic [5:0] b);
        return (a < b) ? a : b;
    endfunction

    // The current lane is used as a one-hot mask and as a 6-bit slice offset (6*lane = 4*lane + 2*lane).
    assign lane_bit   = NUM_LANES'(1) << cur_lane_r;
    assign eye_sh     = {1'b0, cur_lane_r, 2'b00} + {2'b00, cur_lane_r, 1'b0};
    assign cur_eye    = 6'(bus.lane_eye_width >> eye_sh);
    assign cur_ready  = |(bus.lane_ready & lane_bit);
    assign cur_masked = |(mask_r & lane_bit);

    // Main sequencer: abort pre-empts every non-IDLE transition; done is a single-cycle strobe.
    always_ff @(posedge clk160 or negedge totalCounterResetb_manual) begin
        if (!totalCounterResetb_manual) begin
            state      <= S_IDLE;
            mode_r     <= '0;
            ok_r       <= '0;
            fail_r     <= '0;
            mask_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cur_lane_r <= '0;
            eye_min_r  <= '0;
            min_eye_r  <= '0;
            tmo_r      <= '0;
            tmo_cnt    <= '0;
            settle_cnt <= '0;
`ifdef DELAY_SEQ_RETRY_EN
            retry_cnt  <= '0;
            gap_cnt    <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            if (state != S_IDLE && bus.abort) begin
                mode_r <= mode_r & ~lane_bit;
                busy_r <= 1'b0;
                state  <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        busy_r <= 1'b0;
                        if (bus.start) begin
                            mask_r     <= bus.lane_mask;
                            min_eye_r  <= bus.min_eye;
                            tmo_r      <= bus.timeout_cycles;
                            ok_r       <= '0;
                            fail_r     <= '0;
                            mode_r     <= '0;
                            eye_min_r  <= 6'h3f;
                            cur_lane_r <= '0;
                            busy_r     <= 1'b1;
                            state      <= S_SELECT;
                        end
                    end
                    S_SELECT: begin
`ifdef DELAY_SEQ_RETRY_EN
                        retry_cnt <= '0;
`endif
                        state <= cur_masked ? S_ARM : S_NEXT;
                    end
                    S_ARM: begin
                        mode_r     <= mode_r | lane_bit;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // Ready is ignored here; it may still reflect the lane's previous lock.
                        if (settle_cnt == 2'd3) begin
                            tmo_cnt <= '0;
                            state   <= S_WAIT_READY;
                        end else begin
                            settle_cnt <= settle_cnt + 2'd1;
                        end
                    end
                    S_WAIT_READY: begin
                        if (cur_ready) begin
                            state <= S_CHECK;
                        end else if (tmo_r != '0 && tmo_cnt == tmo_r) begin
                            mode_r <= mode_r & ~lane_bit;
`ifdef DELAY_SEQ_RETRY_EN
                            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                                gap_cnt <= 1'b0;
                                state   <= S_RETRY_WAIT;
                            end else begin
                                fail_r <= fail_r | lane_bit;
                                state  <= S_NEXT;
                            end
`else
                            fail_r <= fail_r | lane_bit;
                            state  <= S_NEXT;
`endif
                        end else begin
                            tmo_cnt <= sat_inc(tmo_cnt);
                        end
                    end
                    S_CHECK: begin
                        if (cur_eye >= min_eye_r) begin
                            ok_r      <= ok_r | lane_bit;
                            eye_min_r <= min6(eye_min_r, cur_eye);
                            state     <= S_NEXT;
                        end else begin
                            mode_r <= mode_r & ~lane_bit;
`ifdef DELAY_SEQ_RETRY_EN
                            if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
                                gap_cnt <= 1'b0;
                                state   <= S_RETRY_WAIT;
                            end else begin
                                fail_r <= fail_r | lane_bit;
                                state  <= S_NEXT;
                            end
`else
                            fail_r <= fail_r | lane_bit;
                            state  <= S_NEXT;
`endif
                        end
                    end
`ifdef DELAY_SEQ_RETRY_EN
                    S_RETRY_WAIT: begin
                        // Hold mode low for two cycles so the lane sees a clean restart.
                        if (gap_cnt) begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= S_ARM;
                        end else begin
                            gap_cnt <= 1'b1;
                        end
                    end
`endif
                    S_NEXT: begin
                        if (cur_lane_r == 4'(NUM_LANES - 1)) begin
                            state <= S_FINISH;
                        end else begin
                            cur_lane_r <= cur_lane_r + 4'd1;
                            state      <= S_SELECT;
                        end
                    end
                    S_FINISH: begin
                        if (ok_r == '0) eye_min_r <= 6'd0;
                        done_r <= 1'b1;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.lane_delay_mode = mode_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.cur_lane        = cur_lane_r;
    assign bus.lane_ok         = ok_r;
    assign bus.lane_fail       = fail_r;
    assign bus.eye_min         = eye_min_r;
endmodule

// File: tb/tb_delay_align_sequencer.sv
// tb_delay_align_sequencer: this bench models each lane as a controller that
// raises ready a set number of cycles after its delay_mode goes high. It checks
// the sequencer against a model of the expected per-lane outcome, eye minimum,
// arm count and completion latency.
module tb_delay_align_sequencer;
    localparam int NL    = 8;
    localparam int TW    = 20;
    localparam int MR    = 3;
    localparam int NEVER = 1000000;
`ifdef DELAY_SEQ_RETRY_EN
    localparam int RETRIES = MR;
`else
    localparam int RETRIES = 0;
`endif

    logic clk160 = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk160 = ~clk160;

    delay_align_sequencer_if #(.NUM_LANES(NL), .TIMEOUT_W(TW)) bus ();

    delay_align_sequencer #(.NUM_LANES(NL), .TIMEOUT_W(TW), .MAX_RETRY(MR)) dut (
        .clk160                    (clk160),
        .totalCounterResetb_manual (rst_n),
        .bus                       (bus)
    );

    int tests = 0;
    int fails = 0;

    int ready_dly [NL] = '{default: 0};
    int eye       [NL] = '{default: 0};
    int hi_cnt    [NL] = '{default: 0};
    int arm_cnt   [NL] = '{default: 0};
    logic [NL-1:0] prev_mode = '0;
    int done_cnt = 0;

    logic [NL-1:0] exp_ok, exp_fail;
    int exp_emin, exp_cycles;
    int exp_att [NL];

    // Lane emulation plus monitors for arm events and done pulses.
    always @(negedge clk160) begin
        for (int i = 0; i < NL; i++) begin
            if (bus.lane_delay_mode[i]) begin
                if (hi_cnt[i] < NEVER + 10) hi_cnt[i]++;
            end else begin
                hi_cnt[i] = 0;
            end
            bus.lane_ready[i] = bus.lane_delay_mode[i] && (hi_cnt[i] > ready_dly[i]);
            if (bus.lane_delay_mode[i] && !prev_mode[i]) arm_cnt[i]++;
        end
        prev_mode = bus.lane_delay_mode;
        if (bus.done) done_cnt++;
    end

    // Model of the outcome. Ready is visible in cycle d+1 after mode rises, and
    // the first 4 of those cycles are settle. Each attempt costs
    // ARM + 4 settle + wait + CHECK (no CHECK after a timeout, so T+6 in that
    // case). Each retry adds 2 gap cycles. Every lane also costs SELECT + NEXT.
    task automatic compute_expected(input logic [NL-1:0] mask, input int me, input int t);
        int cyc, a, r;
        bit in_time, pass;
        exp_ok = '0; exp_fail = '0; exp_emin = 63; cyc = 0;
        for (int i = 0; i < NL; i++) begin
            exp_att[i] = 0;
            if (!mask[i]) begin
                cyc += 2;
            end else begin
                in_time = (t == 0) || (ready_dly[i] <= 4) || (ready_dly[i] - 3 <= t + 1);
                if (in_time) a = 6 + ((ready_dly[i] <= 4) ? 1 : ready_dly[i] - 3);
                else         a = t + 6;
                pass = in_time && (eye[i] >= me);
                r = pass ? 0 : RETRIES;
                cyc += 2 + a + r * (a + 2);
                exp_att[i] = 1 + r;
                if (pass) begin
                    exp_ok[i] = 1'b1;
                    if (eye[i] < exp_emin) exp_emin = eye[i];
                end else begin
                    exp_fail[i] = 1'b1;
                end
            end
        end
        if (exp_ok == '0) exp_emin = 0;
        exp_cycles = cyc + 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk160);
        bus.start = 1'b0; bus.abort = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk160);
        rst_n = 1'b1;
    endtask

    task automatic drive_start(input logic [NL-1:0] mask, input int me, input int t, input bit with_abort);
        logic [6*NL-1:0] ew;
        for (int i = 0; i < NL; i++) ew[6*i +: 6] = 6'(eye[i]);
        @(negedge clk160);
        bus.lane_eye_width = ew;
        bus.lane_mask      = mask;
        bus.min_eye        = 6'(me);
        bus.timeout_cycles = TW'(t);
        bus.start          = 1'b1;
        bus.abort          = with_abort;
        @(posedge clk160); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    // Run one sequence and count edges from the start edge to the first cycle
    // where done is seen high. It can also re-pulse start at cycle busy_start_at.
    task automatic run_seq(input logic [NL-1:0] mask, input int me, input int t, input bit with_abort,
                           input int busy_start_at, output int cyc, output bit timed_out,
                           output logic busy_first, output logic done_after, output logic busy_after);
        drive_start(mask, me, t, with_abort);
        busy_first = bus.busy;
        cyc = 0; timed_out = 1'b1;
        repeat (20000) begin
            @(posedge clk160); #1;
            cyc++;
            bus.start = 1'b0;
            bus.lane_mask = mask;
            if (bus.done) begin timed_out = 1'b0; break; end
            if (cyc == busy_start_at) begin bus.start = 1'b1; bus.lane_mask = ~mask; end
        end
        @(posedge clk160); #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        pulse_reset();
        @(posedge clk160); #1;
        tests++;
        if ({bus.lane_delay_mode, bus.lane_ok, bus.lane_fail, bus.busy, bus.done, bus.cur_lane, bus.eye_min} !== '0) begin
            fails++;
            $display("FAIL reset_state got mode=%h ok=%h fail=%h busy=%b done=%b lane=%0d eye_min=%0d want all 0",
                     bus.lane_delay_mode, bus.lane_ok, bus.lane_fail, bus.busy, bus.done, bus.cur_lane, bus.eye_min);
        end
    endtask

    task automatic test_all_pass();
        int cyc, dn0; bit to; logic b1, da, ba;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 10 + i; ready_dly[i] = 20; end
        compute_expected(8'hFF, 4, 0);
        dn0 = done_cnt;
        run_seq(8'hFF, 4, 0, 1'b1, 0, cyc, to, b1, da, ba);
        tests++; if (to) begin fails++; $display("FAIL all_pass.timeout got=no_done want=done"); end
        tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL all_pass.busy_rise got=%b want=1", b1); end
        tests++; if (cyc != exp_cycles) begin fails++; $display("FAIL all_pass.latency got=%0d want=%0d", cyc, exp_cycles); end
        tests++; if (bus.lane_ok !== 8'hFF) begin fails++; $display("FAIL all_pass.lane_ok got=%h want=ff", bus.lane_ok); end
        tests++; if (bus.lane_fail !== 8'h00) begin fails++; $display("FAIL all_pass.lane_fail got=%h want=00", bus.lane_fail); end
        tests++; if (bus.eye_min !== 6'd10) begin fails++; $display("FAIL all_pass.eye_min got=%0d want=10", bus.eye_min); end
        tests++; if (bus.lane_delay_mode !== 8'hFF) begin fails++; $display("FAIL all_pass.mode got=%h want=ff", bus.lane_delay_mode); end
        tests++; if (da !== 1'b0 || ba !== 1'b0) begin fails++; $display("FAIL all_pass.done_busy_fall got done=%b busy=%b want 0 0", da, ba); end
        tests++; if (done_cnt - dn0 != 1) begin fails++; $display("FAIL all_pass.done_count got=%0d want=1", done_cnt - dn0); end
    endtask

    task automatic test_masked();
        int cyc, arm0 [NL]; bit to; logic b1, da, ba;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 30; ready_dly[i] = $urandom_range(0, 10); arm0[i] = arm_cnt[i]; end
        compute_expected(8'h05, 4, 0);
        run_seq(8'h05, 4, 0, 1'b0, 0, cyc, to, b1, da, ba);
        tests++; if (to || cyc != exp_cycles) begin fails++; $display("FAIL masked.latency got=%0d want=%0d", cyc, exp_cycles); end
        tests++; if (bus.lane_ok !== 8'h05) begin fails++; $display("FAIL masked.lane_ok got=%h want=05", bus.lane_ok); end
        tests++; if (bus.lane_fail !== 8'h00) begin fails++; $display("FAIL masked.lane_fail got=%h want=00", bus.lane_fail); end
        tests++; if (bus.lane_delay_mode !== 8'h05) begin fails++; $display("FAIL masked.mode got=%h want=05", bus.lane_delay_mode); end
        for (int i = 0; i < NL; i++) begin
            tests++;
            if (arm_cnt[i] - arm0[i] != ((i == 0 || i == 2) ? 1 : 0)) begin
                fails++; $display("FAIL masked.arms lane%0d got=%0d want=%0d", i, arm_cnt[i] - arm0[i], (i == 0 || i == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc, arm0; bit to; logic b1, da, ba;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 20 + i; ready_dly[i] = (i == 3) ? NEVER : 20; end
        arm0 = arm_cnt[3];
        compute_expected(8'hFF, 4, 100);
        run_seq(8'hFF, 4, 100, 1'b0, 0, cyc, to, b1, da, ba);
        tests++; if (to || cyc != exp_cycles) begin fails++; $display("FAIL timeout.latency got=%0d want=%0d", cyc, exp_cycles); end
        tests++; if (bus.lane_fail !== 8'h08) begin fails++; $display("FAIL timeout.lane_fail got=%h want=08", bus.lane_fail); end
        tests++; if (bus.lane_ok !== 8'hF7) begin fails++; $display("FAIL timeout.lane_ok got=%h want=f7", bus.lane_ok); end
        tests++; if (bus.lane_delay_mode !== 8'hF7) begin fails++; $display("FAIL timeout.mode got=%h want=f7", bus.lane_delay_mode); end
        tests++; if (bus.eye_min !== 6'd20) begin fails++; $display("FAIL timeout.eye_min got=%0d want=20", bus.eye_min); end
        tests++; if (arm_cnt[3] - arm0 != 1 + RETRIES) begin fails++; $display("FAIL timeout.arms got=%0d want=%0d", arm_cnt[3] - arm0, 1 + RETRIES); end
    endtask

    task automatic test_narrow_eye();
        int cyc, arm0; bit to; logic b1, da, ba;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = (i == 5) ? 2 : 30 + i; ready_dly[i] = $urandom_range(0, 8); end
        arm0 = arm_cnt[5];
        compute_expected(8'hFF, 4, 0);
        run_seq(8'hFF, 4, 0, 1'b0, 0, cyc, to, b1, da, ba);
        tests++; if (to || cyc != exp_cycles) begin fails++; $display("FAIL narrow.latency got=%0d want=%0d", cyc, exp_cycles); end
        tests++; if (arm_cnt[5] - arm0 != 1 + RETRIES) begin fails++; $display("FAIL narrow.arms got=%0d want=%0d", arm_cnt[5] - arm0, 1 + RETRIES); end
        tests++; if (bus.lane_fail !== 8'h20 || bus.lane_ok !== 8'hDF) begin fails++; $display("FAIL narrow.result got ok=%h fail=%h want ok=df fail=20", bus.lane_ok, bus.lane_fail); end
        tests++; if (bus.eye_min !== 6'd30) begin fails++; $display("FAIL narrow.eye_min got=%0d want=30", bus.eye_min); end
    endtask

    task automatic test_abort();
        int dn0; bit found; logic was_busy;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 20 + i; ready_dly[i] = (i == 2) ? NEVER : 0; end
        dn0 = done_cnt;
        drive_start(8'hFF, 4, 0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk160); #1;
            if (bus.cur_lane == 4'd2 && bus.lane_delay_mode[2]) begin found = 1'b1; break; end
        end
        tests++; if (!found) begin fails++; $display("FAIL abort.reach_lane2 got=0 want=1"); end
        repeat (8) @(posedge clk160);
        #1;
        was_busy = bus.busy;
        bus.abort = 1'b1;
        @(posedge clk160); #1;
        bus.abort = 1'b0;
        tests++; if (was_busy !== 1'b1) begin fails++; $display("FAIL abort.busy_before got=%b want=1", was_busy); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL abort.busy_after got=%b want=0", bus.busy); end
        tests++; if (bus.lane_delay_mode !== 8'h03) begin fails++; $display("FAIL abort.mode got=%h want=03", bus.lane_delay_mode); end
        tests++; if (bus.lane_ok !== 8'h03 || bus.lane_fail !== 8'h00) begin fails++; $display("FAIL abort.ok_fail got ok=%h fail=%h want ok=03 fail=00", bus.lane_ok, bus.lane_fail); end
        repeat (5) @(posedge clk160);
        #1;
        tests++; if (done_cnt != dn0 || bus.busy !== 1'b0) begin fails++; $display("FAIL abort.no_done got done_pulses=%0d busy=%b want 0 0", done_cnt - dn0, bus.busy); end
    endtask

    task automatic test_reset_mid();
        int dn0;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 40; ready_dly[i] = 0; end
        dn0 = done_cnt;
        drive_start(8'hFF, 4, 0, 1'b0);
        repeat (2) @(posedge clk160);
        #1;
        tests++; if (bus.busy !== 1'b1 || bus.lane_delay_mode !== 8'h01) begin fails++; $display("FAIL reset_mid.in_settle got busy=%b mode=%h want 1 01", bus.busy, bus.lane_delay_mode); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.lane_delay_mode, bus.lane_ok, bus.lane_fail, bus.busy, bus.done, bus.cur_lane, bus.eye_min} !== '0) begin
            fails++; $display("FAIL reset_mid.async_clear got mode=%h busy=%b eye_min=%0d want all 0", bus.lane_delay_mode, bus.busy, bus.eye_min);
        end
        repeat (3) @(negedge clk160);
        rst_n = 1'b1;
        repeat (4) @(posedge clk160);
        #1;
        tests++; if (done_cnt != dn0 || bus.busy !== 1'b0) begin fails++; $display("FAIL reset_mid.no_done got pulses=%0d busy=%b want 0 0", done_cnt - dn0, bus.busy); end
    endtask

    task automatic test_no_pass();
        int cyc, dn0; bit to; logic b1, da, ba;
        pulse_reset();
        for (int i = 0; i < NL; i++) begin eye[i] = 1; ready_dly[i] = $urandom_range(0, 6); end
        compute_expected(8'hFF, 5, 0);
        dn0 = done_cnt;
        run_seq(8'hFF, 5, 0, 1'b0, 15, cyc, to, b1, da, ba);
        tests++; if (to || cyc != exp_cycles) begin fails++; $display("FAIL no_pass.latency got=%0d want=%0d", cyc, exp_cycles); end
        tests++; if (bus.eye_min !== 6'd0) begin fails++; $display("FAIL no_pass.eye_min got=%0d want=0", bus.eye_min); end
        tests++; if (bus.lane_ok !== 8'h00 || bus.lane_fail !== 8'hFF) begin fails++; $display("FAIL no_pass.result got ok=%h fail=%h want ok=00 fail=ff", bus.lane_ok, bus.lane_fail); end
        tests++; if (bus.lane_delay_mode !== 8'h00) begin fails++; $display("FAIL no_pass.mode got=%h want=00", bus.lane_delay_mode); end
        tests++; if (done_cnt - dn0 != 1 || ba !== 1'b0) begin fails++; $display("FAIL no_pass.no_restart got pulses=%0d busy=%b want 1 0", done_cnt - dn0, ba); end
    endtask

    task automatic test_random();
        int cyc, me, t, arm0 [NL]; bit to; logic b1, da, ba; logic [NL-1:0] mask;
        for (int it = 0; it < 6; it++) begin
            mask = NL'($urandom);
            me   = $urandom_range(0, 40);
            t    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 40);
            for (int i = 0; i < NL; i++) begin
                eye[i] = $urandom_range(0, 63);
                ready_dly[i] = (t != 0 && $urandom_range(0, 4) == 0) ? NEVER : $urandom_range(0, 30);
                arm0[i] = arm_cnt[i];
            end
            compute_expected(mask, me, t);
            run_seq(mask, me, t, 1'b0, 0, cyc, to, b1, da, ba);
            tests++; if (to || cyc != exp_cycles) begin fails++; $display("FAIL random%0d.latency got=%0d want=%0d", it, cyc, exp_cycles); end
            tests++; if (bus.lane_ok !== exp_ok || bus.lane_fail !== exp_fail) begin fails++; $display("FAIL random%0d.result got ok=%h fail=%h want ok=%h fail=%h", it, bus.lane_ok, bus.lane_fail, exp_ok, exp_fail); end
            tests++; if (bus.lane_delay_mode !== exp_ok) begin fails++; $display("FAIL random%0d.mode got=%h want=%h", it, bus.lane_delay_mode, exp_ok); end
            tests++; if (bus.eye_min !== 6'(exp_emin)) begin fails++; $display("FAIL random%0d.eye_min got=%0d want=%0d", it, bus.eye_min, exp_emin); end
            for (int i = 0; i < NL; i++) begin
                tests++;
                if (arm_cnt[i] - arm0[i] != exp_att[i]) begin fails++; $display("FAIL random%0d.arms lane%0d got=%0d want=%0d", it, i, arm_cnt[i] - arm0[i], exp_att[i]); end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.lane_mask = '0;
        bus.min_eye = '0;
        bus.timeout_cycles = '0;
        bus.lane_eye_width = '0;
        test_reset();
        test_all_pass();
        test_masked();
        test_timeout();
        test_narrow_eye();
        test_abort();
        test_reset_mid();
        test_no_pass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/delay_align_sequencer.md
# delay_align_sequencer

Sequences automatic bit alignment across up to 16 `delay_ctrl_utility` lanes, one lane at a time.
- Per lane: drives the lane's `delay_mode`, waits for `delay_ready`, and checks `eye_width` against a programmable minimum.
- Records per-lane pass/fail and the smallest eye width among passing lanes.
- Sits between the slow-control register block and the per-lane delay controllers, so one `start` pulse calibrates the whole link.

## Interface
Parameters:
- NUM_LANES, 8, number of lanes sequenced (1..16)
- TIMEOUT_W, 20, width of the per-lane ready-timeout counter
- MAX_RETRY, 3, retries per lane when `DELAY_SEQ_RETRY_EN` is defined

Ports:
- clk160  in  1  system clock
- totalCounterResetb_manual  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  one-cycle abort; honoured in any non-IDLE state
- lane_mask  in  NUM_LANES  1 = lane participates; sampled at start
- min_eye  in  6  minimum acceptable eye_width; sampled at start
- timeout_cycles  in  TIMEOUT_W  ready timeout per attempt; 0 = no timeout
- lane_ready  in  NUM_LANES  per-lane delay_ready
- lane_eye_width  in  6*NUM_LANES  per-lane eye_width, lane i at [6i+5:6i]
- lane_delay_mode  out  NUM_LANES  per-lane delay_mode
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on sequence completion
- cur_lane  out  4  index of lane being processed
- lane_ok  out  NUM_LANES  lane passed
- lane_fail  out  NUM_LANES  lane timed out or eye too narrow
- eye_min  out  6  minimum eye_width over passing lanes

## Operation
States: IDLE, SELECT, ARM, SETTLE, WAIT_READY, CHECK, NEXT, FINISH.

- **IDLE**
  - On `start`: capture `lane_mask`, `min_eye` and `timeout_cycles`.
  - Clear `lane_ok`, `lane_fail` and all of `lane_delay_mode`.
  - Load `eye_min` = 6'h3f and `cur_lane` = 0, then go to SELECT.
- **SELECT**
  - If `cur_lane` is masked in, go to ARM.
  - Otherwise go to NEXT. Masked-out lanes keep ok = fail = mode = 0.
- **ARM**
  - Set `lane_delay_mode[cur_lane]`, clear the settle counter, go to SETTLE.
- **SETTLE**
  - Wait 4 cycles with `lane_ready` ignored; this masks stale ready during the lane's AUTOINIT.
  - Then clear the timeout counter and go to WAIT_READY.
- **WAIT_READY**
  - `lane_ready[cur_lane]` = 1 → CHECK.
  - Else, if `timeout_cycles` ≠ 0 and counter == `timeout_cycles`: set `lane_fail`, clear the lane's mode bit, go to NEXT.
  - Otherwise increment the counter, saturating at all-ones.
- **CHECK**
  - If `eye_width` ≥ `min_eye`: set `lane_ok`, keep `lane_delay_mode` high (phase-2 tracking continues), and set `eye_min` = min(`eye_min`, width).
  - Otherwise set `lane_fail` and clear the mode bit (see Configuration).
  - Go to NEXT.
- **NEXT**
  - If `cur_lane` == NUM_LANES-1, go to FINISH.
  - Otherwise increment `cur_lane` and go to SELECT.
- **FINISH**
  - If no lane is ok, set `eye_min` = 0.
  - Pulse `done`, go to IDLE.

Boundary conditions:
- `abort`: clear the current lane's mode bit, leave other lanes' bits and all ok/fail bits as they are, go to IDLE without pulsing `done`. `abort` takes priority over every other transition.
- Simultaneous `start` and `abort` in IDLE: `start` wins.
- `start` while busy: ignored.
- Timeout and ready arriving in the same cycle: ready wins.
- Reset mid-sequence: every output returns to its reset value immediately; no completion is reported.

## Timing
- Reset values:
  - `lane_delay_mode`, `lane_ok`, `lane_fail`: 0
  - `busy`, `done`: 0
  - `cur_lane`, `eye_min`: 0
  - state = IDLE
- All outputs are registered.
- `busy` rises the cycle after `start`.
- A lane that is ready immediately costs 1 (SELECT) + 1 (ARM) + 4 (SETTLE) + 1 (WAIT_READY) + 1 (CHECK) + 1 (NEXT) = 9 cycles.
- A masked-out lane costs 2 cycles.
- `done` is high for exactly 1 cycle; `busy` falls the cycle after `done`.

## Configuration
- **`DELAY_SEQ_RETRY_EN` defined:**
  - A CHECK or timeout failure with retries left clears the lane's mode bit, waits 2 cycles, increments the retry count and re-enters ARM.
  - `lane_fail` is set only after MAX_RETRY retries have failed.
  - The retry count clears in SELECT.
- **`DELAY_SEQ_RETRY_EN` undefined:** the first failure is final. No retry logic is synthesised.

## Test plan
- **All lanes pass:** mask 8'hFF, min_eye 4, all lanes report ready 20 cycles after mode and eye widths 10..17 → `lane_ok` = 8'hFF, `eye_min` = 10, `done` pulses once.
- **Masked lanes:** mask 8'h05, lanes 0 and 2 pass → `lane_ok` = 8'h05, `lane_fail` = 0, `lane_delay_mode` = 8'h05, lanes 1 and 3-7 never assert mode.
- **Timeout:** timeout_cycles 100, lane 3 never ready → `lane_fail[3]` set after 100 counted cycles per attempt (retry off), `lane_delay_mode[3]` = 0, all other lanes ok.
- **Narrow eye:** lane 5 eye 2 with min_eye 4 and retry on → 4 arm attempts in total, then `lane_fail[5]` set. With retry off → 1 attempt.
- **Abort and reset:** `abort` during lane 2 WAIT_READY → IDLE, no `done`, `lane_delay_mode[2]` = 0, lanes 0 and 1 still ok. Reset asserted in SETTLE → all outputs 0 the same cycle.
- **No passing lanes:** all lanes fail → `eye_min` = 0 at `done`. `start` pulsed while busy → no restart.
